// File: rtl/membus_arb.sv
// membus_arb: four-to-one PDP-10 memory-bus arbiter in front of a single
// core-memory (cmem) slave port.
//
// A round-robin grant is made once per memory cycle and held across the
// address acknowledge, read restart and write restart phases. The granted
// master's request lines are muxed to the slave; slave responses are routed
// back to the granted master only. A watchdog aborts cycles the slave never
// acknowledges and reports non-existent memory with a one-cycle m_nxm pulse.
//
// Ports
//   clk, reset_n           : clock, asynchronous active-low reset
//   m_rq_cyc/m_rd_rq/...   : per-master request lines (bit i = master i)
//   m_ma, m_sel, m_mb_write: per-master packed address/select/write data
//   m_addr_ack, m_rd_rs    : responses, granted master only (combinational)
//   m_nxm                  : registered one-cycle timeout pulse
//   m_mb_read              : slave read data broadcast to all masters
//   grant                  : registered one-hot owner, 0 when idle
//   s_*                    : slave-side request and response lines
module membus_arb #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [3:0]   m_rq_cyc,
    input  logic [3:0]   m_rd_rq,
    input  logic [3:0]   m_wr_rq,
    input  logic [3:0]   m_wr_rs,
    input  logic [3:0]   m_fmc_select,
    input  logic [59:0]  m_ma,
    input  logic [15:0]  m_sel,
    input  logic [143:0] m_mb_write,
    output logic [3:0]   m_addr_ack,
    output logic [3:0]   m_rd_rs,
    output logic [3:0]   m_nxm,
    output logic [35:0]  m_mb_read,
    output logic [3:0]   grant,
    output logic         s_rq_cyc,
    output logic         s_rd_rq,
    output logic         s_wr_rq,
    output logic         s_wr_rs,
    output logic         s_fmc_select,
    output logic [14:0]  s_ma,
    output logic [3:0]   s_sel,
    output logic [35:0]  s_mb_write,
    input  logic         s_addr_ack,
    input  logic         s_rd_rs,
    input  logic [35:0]  s_mb_read
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [9:0] TMO_MAX = 10'(TIMEOUT);

    state_t      state_q;
    logic [3:0]  grant_q;
    logic [1:0]  gidx_q;     // binary index of grant_q, used for the muxes
    logic [1:0]  ptr_q;
    logic        cyc_rd_q;
    logic        cyc_wr_q;
    logic [9:0]  tmo_q;
    logic [3:0]  nxm_q;

    logic [1:0]  win_d;
    logic        win_vld_d;
    logic        done_s;

    // Round-robin pick: scan offsets 3..0 so the smallest offset from ptr wins.
    always_comb begin : arb_pick
        logic [1:0] cand;
        win_d     = ptr_q;
        win_vld_d = 1'b0;
        cand      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (m_rq_cyc[cand]) begin
                win_d     = cand;
                win_vld_d = 1'b1;
            end else begin
                win_d     = win_d;
            end
        end
    end

    // Data-phase completion. A cycle with neither read nor write latched
    // has nothing to wait for but the slave restart, so it completes on s_rd_rs.
    always_comb begin
        done_s = 1'b0;
        if (cyc_wr_q) begin
            done_s = m_wr_rs[gidx_q];
        end else begin
            done_s = s_rd_rs;
        end
    end

    // Arbiter FSM: grant ownership, round-robin pointer, watchdog, nxm pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 4'b0000;
            gidx_q   <= 2'd0;
            ptr_q    <= 2'd0;
            cyc_rd_q <= 1'b0;
            cyc_wr_q <= 1'b0;
            tmo_q    <= 10'd0;
            nxm_q    <= 4'b0000;
        end else begin
            nxm_q <= 4'b0000;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_d) begin
                        grant_q <= 4'b0001 << win_d;
                        gidx_q  <= win_d;
                        ptr_q   <= win_d + 2'd1;
                        tmo_q   <= 10'd0;
                        state_q <= ST_GRANT;
                    end else begin
                        grant_q <= 4'b0000;
                    end
                end
                ST_GRANT: begin
                    // Acknowledge has priority over both abort and timeout.
                    if (s_addr_ack) begin
                        cyc_rd_q <= m_rd_rq[gidx_q];
                        cyc_wr_q <= m_wr_rq[gidx_q];
                        state_q  <= ST_DATA;
                    end else if (!m_rq_cyc[gidx_q]) begin
                        grant_q  <= 4'b0000;
                        state_q  <= ST_IDLE;
                    end else if (tmo_q == TMO_MAX) begin
                        nxm_q    <= grant_q;
                        state_q  <= ST_RELEASE;
                    end else begin
                        tmo_q    <= tmo_q + 10'd1;
                    end
                end
                ST_DATA: begin
                    if (done_s) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_RELEASE: begin
                    // Hold ownership until the master lets go of its request.
                    if (!m_rq_cyc[gidx_q]) begin
                        grant_q <= 4'b0000;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RELEASE;
                    end
                end
                default: begin
                    grant_q <= 4'b0000;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave-side request mux and master-side response routing.
    always_comb begin
        s_rq_cyc     = 1'b0;
        s_rd_rq      = 1'b0;
        s_wr_rq      = 1'b0;
        s_wr_rs      = 1'b0;
        s_fmc_select = 1'b0;
        s_ma         = 15'd0;
        s_sel        = 4'd0;
        s_mb_write   = 36'd0;
        m_addr_ack   = 4'b0000;
        m_rd_rs      = 4'b0000;
        case (state_q)
            ST_GRANT: begin
                s_rq_cyc     = m_rq_cyc[gidx_q];
                s_rd_rq      = m_rd_rq[gidx_q];
                s_wr_rq      = m_wr_rq[gidx_q];
                s_wr_rs      = m_wr_rs[gidx_q];
                s_fmc_select = m_fmc_select[gidx_q];
                s_ma         = m_ma[15*int'(gidx_q) +: 15];
                s_sel        = m_sel[4*int'(gidx_q) +: 4];
                s_mb_write   = m_mb_write[36*int'(gidx_q) +: 36];
                m_addr_ack   = grant_q & {4{s_addr_ack}};
            end
            ST_DATA: begin
                // The slave sees a held cycle even if the master drops rq_cyc.
                s_rq_cyc     = 1'b1;
                s_rd_rq      = cyc_rd_q;
                s_wr_rq      = cyc_wr_q;
                s_wr_rs      = m_wr_rs[gidx_q];
                s_fmc_select = m_fmc_select[gidx_q];
                s_ma         = m_ma[15*int'(gidx_q) +: 15];
                s_sel        = m_sel[4*int'(gidx_q) +: 4];
                s_mb_write   = m_mb_write[36*int'(gidx_q) +: 36];
                m_rd_rs      = grant_q & {4{s_rd_rs}};
            end
            default: begin
                s_rq_cyc     = 1'b0;
            end
        endcase
    end

    assign m_mb_read = s_mb_read;
    assign m_nxm     = nxm_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_membus_arb.sv
// Directed bench for membus_arb with a small expected-value queue.
module tb_membus_arb;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [3:0]   m_rq_cyc = 4'b0, m_rd_rq = 4'b0, m_wr_rq = 4'b0;
    logic [3:0]   m_wr_rs = 4'b0, m_fmc_select = 4'b0;
    logic [59:0]  m_ma = 60'd0;
    logic [15:0]  m_sel = 16'd0;
    logic [143:0] m_mb_write = 144'd0;
    logic [3:0]   m_addr_ack, m_rd_rs, m_nxm, grant;
    logic [35:0]  m_mb_read;
    logic         s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs, s_fmc_select;
    logic [14:0]  s_ma;
    logic [3:0]   s_sel;
    logic [35:0]  s_mb_write;
    logic         s_addr_ack = 1'b0, s_rd_rs = 1'b0;
    logic [35:0]  s_mb_read = 36'd0;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    always #10 clk = ~clk;

    membus_arb #(.TIMEOUT(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_rq_cyc(m_rq_cyc), .m_rd_rq(m_rd_rq), .m_wr_rq(m_wr_rq),
        .m_wr_rs(m_wr_rs), .m_fmc_select(m_fmc_select), .m_ma(m_ma),
        .m_sel(m_sel), .m_mb_write(m_mb_write),
        .m_addr_ack(m_addr_ack), .m_rd_rs(m_rd_rs), .m_nxm(m_nxm),
        .m_mb_read(m_mb_read), .grant(grant),
        .s_rq_cyc(s_rq_cyc), .s_rd_rq(s_rd_rq), .s_wr_rq(s_wr_rq),
        .s_wr_rs(s_wr_rs), .s_fmc_select(s_fmc_select), .s_ma(s_ma),
        .s_sel(s_sel), .s_mb_write(s_mb_write),
        .s_addr_ack(s_addr_ack), .s_rd_rs(s_rd_rs), .s_mb_read(s_mb_read)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [63:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic sb_chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
        end else begin
            e = sb_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (grant == 4'b0000 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        step();
        reset_n = 1'b1;
        #1;
    endtask

    // One complete read cycle for whoever is granted next; the master drops
    // rq_cyc in RELEASE and re-raises it in IDLE only if its keep bit is set.
    task automatic rr_cycle(input logic [3:0] keep);
        int g;
        wait_grant();
        sb_chk("rr_grant", {60'd0, grant});
        g = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) g = i;
        s_addr_ack = 1'b1; step(); s_addr_ack = 1'b0;
        s_rd_rs = 1'b1;    step(); s_rd_rs = 1'b0;
        m_rq_cyc[g] = 1'b0; step();
        if (keep[g]) m_rq_cyc[g] = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        #1 reset_n = 1'b0;
        #10;
        chk("reset_outs", {grant, m_addr_ack, m_rd_rs, m_nxm, s_rq_cyc, s_rd_rq, s_wr_rq, s_wr_rs},
            64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("reset_grant", {60'd0, grant}, 64'd0);

        // ---------------- single read, master 0 ----------------
        m_ma[14:0] = 15'o12345;
        m_rq_cyc[0] = 1'b1;
        m_rd_rq[0] = 1'b1;
        sb_push(64'h1);
        sb_push({49'd0, 15'o12345});
        step();
        sb_chk("rd_grant", {60'd0, grant});
        sb_chk("rd_s_ma", {49'd0, s_ma});
        chk("rd_s_rq_cyc", {63'd0, s_rq_cyc}, 64'd1);
        s_addr_ack = 1'b1;
        #1;
        chk("rd_addr_ack", {60'd0, m_addr_ack}, 64'h1);
        step();
        s_addr_ack = 1'b0;
        s_rd_rs = 1'b1;
        s_mb_read = 36'o777000111222;
        #1;
        chk("rd_rd_rs", {60'd0, m_rd_rs}, 64'h1);
        chk("rd_mb_read", {28'd0, m_mb_read}, {28'd0, 36'o777000111222});
        chk("rd_s_rd_rq", {63'd0, s_rd_rq}, 64'd1);
        step();
        s_rd_rs = 1'b0;
        s_mb_read = 36'd0;
        chk("rd_release", {59'd0, s_rq_cyc, grant}, 64'h1);
        m_rq_cyc[0] = 1'b0;
        m_rd_rq[0] = 1'b0;
        step();
        chk("rd_idle_grant", {60'd0, grant}, 64'd0);

        // ---------------- round-robin from ptr = 0 ----------------
        do_reset();
        m_rq_cyc = 4'b1111;
        m_rd_rq = 4'b1111;
        sb_push(64'h1); sb_push(64'h2); sb_push(64'h4); sb_push(64'h8); sb_push(64'h1);
        for (int i = 0; i < 5; i++) rr_cycle(4'b1111);
        m_rq_cyc[1] = 1'b0;
        sb_push(64'h4); sb_push(64'h8); sb_push(64'h1); sb_push(64'h4);
        for (int i = 0; i < 4; i++) rr_cycle(4'b1101);
        m_rq_cyc = 4'b0000;
        m_rd_rq = 4'b0000;
        step();
        step();
        chk("rr_idle", {60'd0, grant}, 64'd0);

        // ---------------- read-modify-write, master 2 ----------------
        m_mb_write[107:72] = 36'o123456701234;
        m_rq_cyc[2] = 1'b1; m_rd_rq[2] = 1'b1; m_wr_rq[2] = 1'b1;
        wait_grant();
        chk("rmw_grant", {60'd0, grant}, 64'h4);
        s_addr_ack = 1'b1; step(); s_addr_ack = 1'b0;
        chk("rmw_rq", {62'd0, s_rd_rq, s_wr_rq}, 64'h3);
        chk("rmw_mb_write", {28'd0, s_mb_write}, {28'd0, 36'o123456701234});
        s_rd_rs = 1'b1;
        #1;
        chk("rmw_rd_rs", {60'd0, m_rd_rs}, 64'h4);
        step();
        s_rd_rs = 1'b0;
        chk("rmw_hold", {63'd0, s_rq_cyc}, 64'd1);
        m_wr_rs[2] = 1'b1;
        #1;
        chk("rmw_s_wr_rs", {63'd0, s_wr_rs}, 64'd1);
        step();
        chk("rmw_release", {62'd0, s_rq_cyc, s_wr_rs}, 64'd0);
        m_wr_rs[2] = 1'b0;
        m_rq_cyc[2] = 1'b0; m_rd_rq[2] = 1'b0; m_wr_rq[2] = 1'b0;
        step();
        chk("rmw_idle", {60'd0, grant}, 64'd0);

        // ---------------- timeout, master 3, TIMEOUT = 7 ----------------
        // Counting the first cycle of the grant as cycle 1, nxm is in cycle 9.
        m_rq_cyc[3] = 1'b1;
        wait_grant();
        chk("tmo_grant", {60'd0, grant}, 64'h8);
        begin
            logic [3:0] seen;
            seen = 4'b0000;
            for (int k = 1; k <= 7; k++) begin
                step();
                seen = seen | m_nxm;
            end
            chk("tmo_early", {60'd0, seen}, 64'd0);
        end
        step();
        chk("tmo_nxm", {59'd0, s_rq_cyc, m_nxm}, 64'h8);
        step();
        chk("tmo_pulse_end", {56'd0, m_nxm, grant}, 64'h08);
        m_rq_cyc[3] = 1'b0;
        step();
        chk("tmo_idle", {60'd0, grant}, 64'd0);

        // Acknowledge coinciding with expiry proceeds to DATA, no nxm.
        m_rq_cyc[3] = 1'b1; m_rd_rq[3] = 1'b1;
        wait_grant();
        for (int k = 1; k <= 7; k++) step();
        s_addr_ack = 1'b1;
        step();
        s_addr_ack = 1'b0;
        chk("tmo_ack_wins", {58'd0, s_rq_cyc, s_rd_rq, m_nxm}, 64'h30);
        s_rd_rs = 1'b1; step(); s_rd_rs = 1'b0;
        m_rq_cyc[3] = 1'b0; m_rd_rq[3] = 1'b0;
        step();

        // ---------------- abort, master 1 ----------------
        m_rq_cyc[1] = 1'b1; m_rd_rq[1] = 1'b1;
        wait_grant();
        chk("abort_grant", {60'd0, grant}, 64'h2);
        step();
        m_rq_cyc[1] = 1'b0; m_rd_rq[1] = 1'b0;
        step();
        chk("abort_idle", {59'd0, s_rq_cyc, grant}, 64'd0);
        s_addr_ack = 1'b1;
        #1;
        chk("abort_no_ack", {60'd0, m_addr_ack}, 64'd0);
        s_addr_ack = 1'b0;
        step();

        // ---------------- reset mid-write ----------------
        m_ma[14:0] = 15'o7070;
        m_rq_cyc[0] = 1'b1; m_wr_rq[0] = 1'b1;
        wait_grant();
        s_addr_ack = 1'b1; step(); s_addr_ack = 1'b0;
        chk("rst_in_data", {63'd0, s_wr_rq}, 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {grant, m_addr_ack, m_rd_rs, m_nxm, s_rq_cyc, s_wr_rq, s_wr_rs, s_ma},
            64'd0);
        m_rq_cyc = 4'b0000; m_wr_rq = 4'b0000;
        step();
        reset_n = 1'b1;
        step();
        chk("rst_grant", {60'd0, grant}, 64'd0);
        m_rq_cyc = 4'b1111;
        step();
        chk("rst_first_arb", {60'd0, grant}, 64'h1);
        m_rq_cyc = 4'b0000;
        step();
        step();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
